// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS pipeline blocks: data-memory geometry and
// the read-return state type used by the data-memory arbiter.
package mips_pkg;

   localparam int unsigned DMEM_AW = 6;

   typedef enum logic [1:0] {
      RET_NONE,
      RET_CPU,
      RET_DBG
   } ret_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the MEM stage (priority) and a
// debug/loader port, with a starvation counter guaranteeing debug a slot.
module dmem_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned AW     = DMEM_AW,
   parameter int unsigned DW     = 32,
   parameter int unsigned STARVE = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE);

   ret_state_t    r_state;
   logic [3:0]    r_starve_cnt;
   logic [DW-1:0] r_dbg_rdata;
   logic          r_dbg_rvalid;

   logic w_starved;
   logic w_dbg_win;
   logic w_cpu_gnt;

   assign w_starved = (r_starve_cnt >= STARVE_LIM);
   assign w_dbg_win = dbg_req & (~cpu_req | w_starved);
   assign w_cpu_gnt = cpu_req & ~w_dbg_win;

   assign dbg_gnt   = w_dbg_win;
   assign cpu_stall = cpu_req & w_dbg_win;

   assign ram_addr  = w_dbg_win ? dbg_addr  : cpu_addr;
   assign ram_din   = w_dbg_win ? dbg_wdata : cpu_wdata;
   assign ram_we    = (w_cpu_gnt & cpu_we) | (w_dbg_win & dbg_we);

   // The RAM output is registered, so the CPU simply samples it the cycle after its grant.
   assign cpu_rdata  = ram_dout;
   assign dbg_rdata  = r_dbg_rdata;
   assign dbg_rvalid = r_dbg_rvalid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= RET_NONE;
         r_starve_cnt <= '0;
         r_dbg_rdata  <= '0;
         r_dbg_rvalid <= 1'b0;
      end else begin
         if (dbg_req & ~w_dbg_win) begin
            if (!w_starved)
               r_starve_cnt <= r_starve_cnt + 4'd1;
         end else begin
            r_starve_cnt <= '0;
         end

         if (w_dbg_win & ~dbg_we)
            r_state <= RET_DBG;
         else if (w_cpu_gnt & ~cpu_we)
            r_state <= RET_CPU;
         else
            r_state <= RET_NONE;

         if (r_state == RET_DBG)
            r_dbg_rdata <= ram_dout;
         r_dbg_rvalid <= (r_state == RET_DBG);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural RAM, a reference memory
// model driving expected read returns, and a monitor popping them.
module tb_dmem_arbiter;
   import mips_pkg::*;

   localparam int AW     = 6;
   localparam int DW     = 32;
   localparam int STARVE = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din, ram_dout;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Behavioural single-port RAM, read-first, 1-cycle read latency
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          cq[$];
   exp_t          dq[$];
   logic [DW-1:0] ref_mem [64];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            denied   = 0;
   bit            last_dgnt;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: drive, check grant/mux against the rules, record expectations
   task automatic step(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input bit dreq, input bit dwe,
                       input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
      bit dwin, cgnt;
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
      @(negedge clk);
      dwin = dreq && (!creq || denied == STARVE);
      cgnt = creq && !dwin;
      chk("dbg_gnt", dbg_gnt, dwin);
      chk("cpu_stall", cpu_stall, creq && dwin);
      chk("ram_we", ram_we, (cgnt && cwe) || (dwin && dwe));
      if (dwin) begin
         chk("ram_addr_dbg", ram_addr, daddr);
         if (dwe) begin
            chk("ram_din_dbg", ram_din, dwd);
            ref_mem[daddr] = dwd;
         end else begin
            dq.push_back('{cyc + 2, ref_mem[daddr]});
         end
      end else begin
         chk("ram_addr_cpu", ram_addr, caddr);
         if (cgnt && cwe) begin
            chk("ram_din_cpu", ram_din, cwd);
            ref_mem[caddr] = cwd;
         end else if (cgnt) begin
            cq.push_back('{cyc + 1, ref_mem[caddr]});
         end
      end
      denied    = (dreq && !dwin) ? ((denied < STARVE) ? denied + 1 : STARVE) : 0;
      last_dgnt = dwin;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      reset = 1'b0;
      cq.delete();
      dq.delete();
      denied = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Monitor: read returns must appear exactly when due and nowhere else
   initial begin
      exp_t e;
      bit   exp_rv;
      forever begin
         @(negedge clk);
         exp_rv = (dq.size() > 0) && (dq[0].cyc == cyc);
         chk("dbg_rvalid", dbg_rvalid, exp_rv);
         if (exp_rv) begin
            e = dq.pop_front();
            chk("dbg_rdata", dbg_rdata, e.data);
         end
         if ((cq.size() > 0) && (cq[0].cyc == cyc)) begin
            e = cq.pop_front();
            chk("cpu_rdata", cpu_rdata, e.data);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit            dpend, dwe_r, creq, cwe;
      logic [AW-1:0] daddr_r, caddr;
      logic [DW-1:0] dwd_r, cwd;
      int            a;

      for (int i = 0; i < 64; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      do_reset();
      chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      chk("rst_dbg_rdata", dbg_rdata, '0);
      idle();

      // CPU write then read of addr 5
      step(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0);
      idle();

      // Debug read of addr 5 with CPU idle
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd5, '0);
      idle(); idle(); idle();

      // Starvation: CPU busy, debug write waits STARVE cycles then wins once
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 6'(i), '0, 1'b1, 1'b1, 6'd10, 32'hA5A5_0001);
      end
      step(1'b1, 1'b0, 6'd10, '0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 6'd10, '0, 1'b1, 1'b0, 6'd10, '0);
      end
      idle(); idle();

      // Debug write to the top address, then CPU read of it
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd63, 32'h12345678);
      step(1'b1, 1'b0, 6'd63, '0, 1'b0, 1'b0, '0, '0);
      idle();

      // Reset between debug read grant and its return
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd63, '0);
      do_reset();
      chk("midrst_dbg_rdata", dbg_rdata, '0);
      idle(); idle(); idle();

      // Debug request dropped before grant under CPU traffic
      step(1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b1, 6'd20, 32'hBAD0_BAD0);
      step(1'b1, 1'b0, 6'd2, '0, 1'b1, 1'b1, 6'd20, 32'hBAD0_BAD0);
      step(1'b1, 1'b0, 6'd20, '0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 6'd3, '0, 1'b1, 1'b0, 6'd20, '0);
      end
      idle(); idle();

      // Randomized traffic; debug holds its request until granted
      dpend = 1'b0; dwe_r = 1'b0; daddr_r = '0; dwd_r = '0;
      for (int n = 0; n < 500; n++) begin
         creq  = ($urandom_range(0, 9) < 6);
         cwe   = $urandom_range(0, 1) == 1;
         a     = $urandom_range(0, 9);
         caddr = (a > 7) ? 6'(a + 54) : 6'(a);
         cwd   = $urandom;
         if (!dpend && ($urandom_range(0, 9) < 3)) begin
            dpend   = 1'b1;
            dwe_r   = $urandom_range(0, 1) == 1;
            a       = $urandom_range(0, 9);
            daddr_r = (a > 7) ? 6'(a + 54) : 6'(a);
            dwd_r   = $urandom;
         end
         step(creq, cwe, caddr, cwd, dpend, dwe_r, daddr_r, dwd_r);
         if (last_dgnt) dpend = 1'b0;
      end
      idle(); idle(); idle(); idle();

      chk("cpu_queue_drained", 64'(cq.size()), 64'd0);
      chk("dbg_queue_drained", 64'(dq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
